// File: rtl/and_22_pkg.sv
// ============================================================================
//  Module      : and_22_pkg
//  Description : Shared datapath constants for the and_22 qualifier/flag AND
//                block: default operand width and the register reset value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package and_22_pkg;

    // Default operand/result width: a single control qualifier and status flag
    localparam int c_default_width = 1;

    // Widest supported operand; reset value is sliced down to WIDTH bits
    localparam int c_max_width = 64;

    // Value loaded into the pipeline register on reset and on flush
    localparam logic [c_max_width-1:0] c_reset_value = '0;

endpackage : and_22_pkg

`default_nettype wire

// File: rtl/and_22_reg.sv
// ============================================================================
//  Module      : and_22_reg
//  Description : WIDTH-bit pipeline register with asynchronous active-low
//                clear, synchronous flush (bubble insert) and load enable.
//                Flush takes priority over load; en=0 holds the value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_22_reg
    import and_22_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next-state select: flush beats load, otherwise hold (stall)
    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = c_reset_value[WIDTH-1:0];
        end else if (en) begin
            q_d = d;
        end
    end

    // State register; reset clears immediately without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= c_reset_value[WIDTH-1:0];
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : and_22_reg

`default_nettype wire

// File: rtl/and_22.sv
// ============================================================================
//  Module      : and_22
//  Description : Bitwise AND of two operands (e.g. Branch & Zero -> PCSrc).
//                Provides the raw combinational product for same-cycle use
//                and a stage-boundary registered copy with stall/flush, plus
//                any/all reductions taken from the registered copy only.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_22
    import and_22_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             any_q,
    output logic             all_q
);

    logic [WIDTH-1:0] w_and;

    // Raw product; independent of clock and reset, X/Z propagate unmasked
    always_comb begin
        w_and = a & b;
    end

    assign c = w_and;

    // Pipeline copy of the product for use in the next stage
    and_22_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flush (flush),
        .d     (w_and),
        .q     (c_q)
    );

    // Reductions derive from the registered value, so they share its latency
    always_comb begin
        any_q = |c_q;
        all_q = &c_q;
    end

endmodule : and_22

`default_nettype wire

// File: tb/tb_and_22.sv
// ============================================================================
//  Module      : tb_and_22
//  Description : Self-checking bench for and_22 at WIDTH=1 and WIDTH=8.
//                Directed steps followed by randomized cycles checked against
//                a behavioural model of the pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and_22;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       c1, c_q1, any_q1, all_q1;
    logic [7:0] c8, c_q8;
    logic       any_q8, all_q8;

    // Model state: what each registered output should currently hold
    logic       exp1;
    logic [7:0] exp8;

    int errors;
    int checks;

    and_22 #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .en    (en),
        .flush (flush),
        .c     (c1),
        .c_q   (c_q1),
        .any_q (any_q1),
        .all_q (all_q1)
    );

    and_22 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .en    (en),
        .flush (flush),
        .c     (c8),
        .c_q   (c_q8),
        .any_q (any_q8),
        .all_q (all_q8)
    );

    // Gated clock so the truth-table phase runs with no edges at all
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every registered output against the model
    task automatic chk_regs(input string tag);
        chk({tag, ".c_q1"},   {63'd0, c_q1},   {63'd0, exp1});
        chk({tag, ".any_q1"}, {63'd0, any_q1}, {63'd0, exp1 == 1'b1});
        chk({tag, ".all_q1"}, {63'd0, all_q1}, {63'd0, exp1 == 1'b1});
        chk({tag, ".c_q8"},   {56'd0, c_q8},   {56'd0, exp8});
        chk({tag, ".any_q8"}, {63'd0, any_q8}, {63'd0, exp8 != 8'h00});
        chk({tag, ".all_q8"}, {63'd0, all_q8}, {63'd0, exp8 == 8'hFF});
    endtask

    // Advance one rising edge; model captures the pre-edge inputs
    task automatic tick();
        logic       n1;
        logic [7:0] n8;
        if (flush) begin
            n1 = 1'b0;
            n8 = 8'h00;
        end else if (en) begin
            n1 = a1 & b1;
            n8 = a8 & b8;
        end else begin
            n1 = exp1;
            n8 = exp8;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp1 = n1;
            exp8 = n8;
        end
    endtask

    initial begin
        logic [1:0] pat;
        errors  = 0;
        checks  = 0;
        clk_run = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        exp1 = 1'b0;
        exp8 = 8'h00;
        #1;

        // Reset state, no clock
        chk_regs("reset");

        // Truth table with no clock running, reset still asserted
        for (int i = 0; i < 4; i++) begin
            pat = i[1:0];
            a1 = pat[1];
            b1 = pat[0];
            #1;
            chk("truth.c1", {63'd0, c1}, {63'd0, (i == 3) ? 1'b1 : 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            #10;
            chk("hold11.c1", {63'd0, c1}, 64'd1);
        end

        // Vector combinational product during reset
        a8 = 8'hF0; b8 = 8'h3C;
        #1;
        chk("vec.c8", {56'd0, c8}, 64'h30);

        // Release reset between edges and start the clock
        rst_n   = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        en      = 1'b1;
        clk_run = 1'b1;
        #1;
        chk_regs("pre_edge");
        tick();
        chk_regs("first_load");
        chk("first_load.c_q1", {63'd0, c_q1}, 64'd1);
        chk("vec_load.c_q8", {56'd0, c_q8}, 64'h30);
        chk("vec_load.any8", {63'd0, any_q8}, 64'd1);
        chk("vec_load.all8", {63'd0, all_q8}, 64'd0);

        // Stall: hold across three edges while the raw product changes
        en = 1'b0;
        a1 = 1'b0;
        a8 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.c_q1", {63'd0, c_q1}, 64'd1);
            chk("stall.c1",   {63'd0, c1},   64'd0);
        end
        chk_regs("stall");

        // Flush wins over enable, then normal load resumes
        en = 1'b1; flush = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF;
        tick();
        chk("flush.c_q1", {63'd0, c_q1}, 64'd0);
        chk_regs("flush");
        flush = 1'b0;
        tick();
        chk("after_flush.c_q1", {63'd0, c_q1}, 64'd1);
        chk("after_flush.all8", {63'd0, all_q8}, 64'd1);
        chk_regs("after_flush");

        // Async reset between edges clears outputs with no clock edge
        #2;
        rst_n = 1'b0;
        exp1 = 1'b0;
        exp8 = 8'h00;
        #1;
        chk("async.c_q1",  {63'd0, c_q1},  64'd0);
        chk("async.any_q1", {63'd0, any_q1}, 64'd0);
        chk("async.all_q1", {63'd0, all_q1}, 64'd0);
        chk_regs("async");
        rst_n = 1'b1;
        tick();
        chk("post_reset.c_q1", {63'd0, c_q1}, 64'd1);
        chk_regs("post_reset");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if ((i % 16) < 4) b8 = a8;
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            chk("rand.c1", {63'd0, c1}, {63'd0, a1 & b1});
            chk("rand.c8", {56'd0, c8}, {56'd0, a8 & b8});
            tick();
            chk_regs("rand");
        end

        clk_run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_and_22

`default_nettype wire

// File: doc/and_22.md
# and_22

Two-input bitwise AND block for the pipelined MIPS datapath, used to combine a control qualifier with a status flag, e.g. Branch & Zero to form PCSrc. It provides the raw combinational product for same-cycle use. It also provides a pipeline-registered copy with stall and flush control, so the result can cross a stage boundary. The default width is 1 bit; a parameter allows vector use.

## Interface
- WIDTH, default 1: operand and result width in bits (legal range 1..64).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; clears all state.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- en  input  1  register load enable; 0 = stall (hold).
- flush  input  1  synchronous clear of registered outputs (pipeline bubble).
- c  output  WIDTH  combinational a & b.
- c_q  output  WIDTH  registered a & b.
- any_q  output  1  reduction OR of c_q.
- all_q  output  1  reduction AND of c_q.

## Operation
- c = a & b, bitwise, purely combinational and independent of clk and rst_n. Truth per bit: 00→0, 01→0, 10→0, 11→1.
- Register update at each rising clk edge, when rst_n is high, in priority order:
  - flush=1: c_q ← 0, regardless of en.
  - else en=1: c_q ← a & b.
  - else: c_q holds its value.
- any_q = |c_q and all_q = &c_q. Both are registered: they derive from c_q only, never from c.
- X or Z on a or b propagates per IEEE bitwise AND semantics. There is no masking.

## Timing
- c: zero-cycle latency, combinational path only.
- c_q, any_q, all_q: one-cycle latency from the a/b sample at an enabled edge.
- Reset values: c_q = 0, any_q = 0, all_q = 0 (1 only if WIDTH = 0, which is illegal). c follows its inputs even during reset.
- Reset assertion clears registered outputs immediately, with no clock needed. Deassertion is taken synchronously to clk by the surrounding reset synchronizer.
- Reset mid-stall or mid-flush: reset wins and the outputs are 0. The first edge after deassertion applies the normal flush/en rules.
- Simultaneous flush=1 and en=1: the result is 0 (flush has priority).

## Structure
- Shared package (datapath package): default WIDTH constant and the reset-value constant (all zeros).
- One natural sub-module, and_22_reg: a WIDTH-bit register with async active-low clear, synchronous flush and load enable. The top level instantiates it once, fed by the combinational AND, and derives the reductions from its output.
- No state machine; the only state is c_q.

## Test plan
- Truth table, WIDTH=1: drive a/b through 00, 01, 10, 11 with no clock. Required: c = 0, 0, 0, 1 immediately. With a=1, b=1 held for 100 ns, c = 1 throughout.
- Registered path: rst_n deasserted, en=1, a=1, b=1. Required: c_q = 1, any_q = 1, all_q = 1 after the next rising edge, and 0 before it.
- Stall: c_q=1 latched, then en=0 with a=0. Required: c_q stays 1 across 3 edges while c = 0.
- Flush priority: en=1, flush=1, a=b=1. Required: c_q = 0 after the edge. With flush=0 on the next edge, c_q = 1.
- Async reset mid-operation: c_q=1, then drop rst_n between edges. Required: c_q, any_q and all_q go to 0 within the same time step with no edge. After release with en=1, a=b=1, c_q = 1 one edge later.
- Vector, WIDTH=8: a=8'hF0, b=8'h3C. Required: c = 8'h30. After an enabled edge, c_q = 8'h30, any_q = 1, all_q = 0.
